memory_interface: RTL and testbench

- Byte-addressed RAM plus handshake controller directly downstream of data_path.
- Serves the data path's instruction fetches and loads/stores using the MFA/MOC protocol: data path raises mfa, block performs a multi-cycle transfer and answers with moc.
- Moves one byte per clock, big-endian: the lowest address holds the most significant byte.
- Supports byte, halfword and word accesses, with signed or unsigned extension on loads.

---
 rtl/memory_interface_pkg.sv | 39 +++
 rtl/memory_interface_if.sv | 29 ++
 rtl/memory_interface_ram_byte_array.sv | 20 ++
 rtl/memory_interface.sv | 152 +++++++++++++++
 tb/tb_memory_interface.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/memory_interface_pkg.sv
// Shared encodings for the memory_interface block: size codes, FSM states,
// rw polarity and the alignment/length helpers used by the controller.
package memory_interface_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01,
    ST_ACK  = 2'b10
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Index of the final byte of an item (N-1); byte count is 1/2/4.
  function automatic logic [1:0] last_idx(input size_e sz);
    case (sz)
      SZ_HALF: last_idx = 2'd1;
      SZ_WORD: last_idx = 2'd3;
      default: last_idx = 2'd0;
    endcase
  endfunction

  function automatic logic access_ok(input size_e sz, input logic [1:0] lsb);
    case (sz)
      SZ_BYTE: access_ok = 1'b1;
      SZ_HALF: access_ok = (lsb[0] == 1'b0);
      SZ_WORD: access_ok = (lsb == 2'b00);
      default: access_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/memory_interface_if.sv
// MFA/MOC bus between data_path (master) and memory_interface (slave).
// mfa is a level request sampled on rising edges; the slave captures the
// command on the first edge with mfa=1 in IDLE, raises moc when done and
// holds it until it samples mfa=0, after which a new request may be taken.
interface memory_interface_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) ();
  logic                  mfa;
  logic                  rw;
  logic [1:0]            size;
  logic                  signed_ld;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  moc;
  logic                  err;
  memory_interface_pkg::state_e state_dbg;

  modport master (
    output mfa, rw, size, signed_ld, address, data_in,
    input  data_out, moc, err, state_dbg
  );

  modport slave (
    input  mfa, rw, size, signed_ld, address, data_in,
    output data_out, moc, err, state_dbg
  );
endinterface

// File: rtl/memory_interface_ram_byte_array.sv
// Single-port byte RAM: synchronous write, combinational read.
// Contents are never reset so a bench can preload them hierarchically.
module ram_byte_array #(
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 512
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);
  reg [7:0] memory [0:DEPTH-1];

  always @(posedge clk) begin
    if (we) memory[addr] <= wdata;
  end

  assign rdata = memory[addr];
endmodule

// File: rtl/memory_interface.sv
// MFA/MOC memory controller: moves one byte per clock, big-endian, between
// the data path and a byte RAM, with sign/zero extension on narrow loads.
module memory_interface
  import memory_interface_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 512,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 main_clk,
  input  logic                 reset,
  memory_interface_if.slave    bus
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rw_q, rw_d;
  size_e                 size_q, size_d;
  logic                  sgn_q, sgn_d;
  logic                  bad_q, bad_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  moc_q, moc_d;
  logic                  err_q, err_d;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [7:0]            ram_wdata;
  logic [7:0]            ram_rdata;
  logic [1:0]            byte_sel;
  logic [DATA_WIDTH-1:0] asm_next;
  logic [DATA_WIDTH-1:0] ext_val;

  // Address wraps modulo DEPTH through ADDR_WIDTH truncation (DEPTH = 2**ADDR_WIDTH).
  assign ram_addr  = addr_q + ADDR_WIDTH'(cnt_q);
  assign byte_sel  = last_idx(size_q) - cnt_q;
  assign ram_wdata = wdat_q[{byte_sel, 3'b000} +: 8];
  assign asm_next  = {asm_q[DATA_WIDTH-9:0], ram_rdata};

  always_comb begin
    case (size_q)
      SZ_BYTE: ext_val = {{(DATA_WIDTH-8){sgn_q & asm_next[7]}}, asm_next[7:0]};
      SZ_HALF: ext_val = {{(DATA_WIDTH-16){sgn_q & asm_next[15]}}, asm_next[15:0]};
      default: ext_val = asm_next;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    bad_d   = bad_q;
    wdat_d  = wdat_q;
    asm_d   = asm_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    moc_d   = moc_q;
    err_d   = err_q;
    ram_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.mfa) begin
          addr_d  = bus.address;
          rw_d    = bus.rw;
          size_d  = size_e'(bus.size);
          sgn_d   = bus.signed_ld;
          wdat_d  = bus.data_in;
          asm_d   = '0;
          cnt_d   = 2'd0;
          bad_d   = ~access_ok(size_e'(bus.size), bus.address[1:0]);
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        // A rejected access spends one idle XFER cycle so moc rises after E+1.
        if (bad_q) begin
          dout_d  = '0;
          err_d   = 1'b1;
          moc_d   = 1'b1;
          state_d = ST_ACK;
        end else begin
          ram_we = (rw_q == RW_WRITE);
          asm_d  = asm_next;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == last_idx(size_q)) begin
            if (rw_q == RW_READ) dout_d = ext_val;
            err_d   = 1'b0;
            moc_d   = 1'b1;
            state_d = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        if (!bus.mfa) begin
          moc_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge main_clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rw_q    <= RW_READ;
      size_q  <= SZ_BYTE;
      sgn_q   <= 1'b0;
      bad_q   <= 1'b0;
      wdat_q  <= '0;
      asm_q   <= '0;
      dout_q  <= '0;
      cnt_q   <= 2'd0;
      moc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      bad_q   <= bad_d;
      wdat_q  <= wdat_d;
      asm_q   <= asm_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      moc_q   <= moc_d;
      err_q   <= err_d;
    end
  end

  assign bus.data_out  = dout_q;
  assign bus.moc       = moc_q;
  assign bus.err       = err_q;
  assign bus.state_dbg = state_q;

  ram_byte_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) ram (
    .clk   (main_clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );
endmodule

// File: tb/tb_memory_interface.sv
// Directed bench for memory_interface: big-endian transfers, extension,
// alignment errors, reset mid-transfer and mfa/moc handshake corner cases.
module tb_memory_interface;
  import memory_interface_pkg::*;

  logic main_clk = 1'b0;
  logic reset    = 1'b0;
  int   n_cmp    = 0;
  int   n_bad    = 0;

  memory_interface_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) bus ();

  memory_interface #(.ADDR_WIDTH(9), .DEPTH(512), .DATA_WIDTH(32)) dut (
    .main_clk (main_clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 main_clk = ~main_clk;

  // Issue one request, wait (bounded) for moc, then release mfa for one edge.
  task automatic do_access(input logic rw, input logic [1:0] sz, input logic sgn,
                           input logic [8:0] addr, input logic [31:0] din,
                           output logic [31:0] dout, output logic err, output int edges);
    logic got;
    @(negedge main_clk);
    bus.rw = rw; bus.size = sz; bus.signed_ld = sgn; bus.address = addr; bus.data_in = din;
    bus.mfa = 1'b1;
    edges = 0; got = 1'b0;
    while (!got && edges < 20) begin
      @(posedge main_clk); #1;
      edges++;
      if (bus.moc) got = 1'b1;
    end
    dout = bus.data_out; err = bus.err;
    if (!got) edges = -1;
    @(negedge main_clk);
    bus.mfa = 1'b0;
    @(posedge main_clk); #1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (bus.moc !== 1'b0) begin n_bad++; $display("FAIL reset_moc: got %b want 0", bus.moc); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
    n_cmp++; if (bus.data_out !== 32'h0) begin n_bad++; $display("FAIL reset_dout: got %h want 0", bus.data_out); end
    n_cmp++; if (bus.state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", bus.state_dbg, ST_IDLE); end
    repeat (2) @(negedge main_clk);
    reset = 1'b1;
  endtask

  task automatic test_word_read();
    logic [31:0] d; logic e; int n;
    dut.ram.memory[0] = 8'hE3; dut.ram.memory[1] = 8'hA0;
    dut.ram.memory[2] = 8'h10; dut.ram.memory[3] = 8'h05;
    do_access(RW_READ, SZ_WORD, 1'b0, 9'd0, 32'h0, d, e, n);
    n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL word_read_latency: got %0d want 5", n); end
    n_cmp++; if (d !== 32'hE3A01005) begin n_bad++; $display("FAIL word_read_data: got %h want E3A01005", d); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL word_read_err: got %b want 0", e); end
  endtask

  task automatic test_word_write();
    logic [31:0] d; logic e; int n;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hDE; exp_b[1] = 8'hAD; exp_b[2] = 8'hBE; exp_b[3] = 8'hEF;
    do_access(RW_WRITE, SZ_WORD, 1'b0, 9'd8, 32'hDEADBEEF, d, e, n);
    n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL word_write_latency: got %0d want 5", n); end
    n_cmp++; if (d !== 32'hE3A01005) begin n_bad++; $display("FAIL write_keeps_dout: got %h want E3A01005", d); end
    n_cmp++; if (dut.ram.memory[8] !== 8'hDE) begin n_bad++; $display("FAIL word_write_mem8: got %h want DE", dut.ram.memory[8]); end
    for (int i = 0; i < 4; i++) begin
      do_access(RW_READ, SZ_BYTE, 1'b0, 9'(8 + i), 32'h0, d, e, n);
      n_cmp++; if (d !== {24'h0, exp_b[i]}) begin n_bad++; $display("FAIL byte_readback_%0d: got %h want %h", 8 + i, d, {24'h0, exp_b[i]}); end
      n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL byte_latency_%0d: got %0d want 2", 8 + i, n); end
    end
  endtask

  task automatic test_sign_ext();
    logic [31:0] d; logic e; int n;
    dut.ram.memory[16] = 8'h80; dut.ram.memory[18] = 8'h80; dut.ram.memory[19] = 8'h01;
    do_access(RW_READ, SZ_BYTE, 1'b0, 9'd16, 32'h0, d, e, n);
    n_cmp++; if (d !== 32'h00000080) begin n_bad++; $display("FAIL byte_zext: got %h want 00000080", d); end
    do_access(RW_READ, SZ_BYTE, 1'b1, 9'd16, 32'h0, d, e, n);
    n_cmp++; if (d !== 32'hFFFFFF80) begin n_bad++; $display("FAIL byte_sext: got %h want FFFFFF80", d); end
    do_access(RW_READ, SZ_HALF, 1'b1, 9'd18, 32'h0, d, e, n);
    n_cmp++; if (d !== 32'hFFFF8001) begin n_bad++; $display("FAIL half_sext: got %h want FFFF8001", d); end
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL half_latency: got %0d want 3", n); end
    do_access(RW_READ, SZ_HALF, 1'b0, 9'd18, 32'h0, d, e, n);
    n_cmp++; if (d !== 32'h00008001) begin n_bad++; $display("FAIL half_zext: got %h want 00008001", d); end
  endtask

  task automatic test_misaligned();
    logic [31:0] d; logic e; int n;
    dut.ram.memory[4] = 8'h11; dut.ram.memory[5] = 8'h22;
    dut.ram.memory[6] = 8'h33; dut.ram.memory[7] = 8'h44;
    do_access(RW_READ, SZ_WORD, 1'b0, 9'd2, 32'h0, d, e, n);
    n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL mis_word_latency: got %0d want 2", n); end
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL mis_word_err: got %b want 1", e); end
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL mis_word_dout: got %h want 0", d); end
    do_access(RW_WRITE, SZ_HALF, 1'b0, 9'd5, 32'h0000BEEF, d, e, n);
    n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL mis_half_latency: got %0d want 2", n); end
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL mis_half_err: got %b want 1", e); end
    n_cmp++; if ({dut.ram.memory[5], dut.ram.memory[6]} !== 16'h2233) begin n_bad++; $display("FAIL mis_half_mem: got %h want 2233", {dut.ram.memory[5], dut.ram.memory[6]}); end
    do_access(RW_READ, 2'b11, 1'b0, 9'd4, 32'h0, d, e, n);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL rsvd_err: got %b want 1", e); end
    do_access(RW_READ, SZ_BYTE, 1'b0, 9'd7, 32'h0, d, e, n);
    n_cmp++; if (e !== 1'b0 || d !== 32'h00000044) begin n_bad++; $display("FAIL odd_byte: got err=%b %h want err=0 00000044", e, d); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL err_clear_idle: got %b want 0", bus.err); end
  endtask

  task automatic test_reset_xfer();
    logic [31:0] d; logic e; int n;
    dut.ram.memory[20] = 8'hAA; dut.ram.memory[21] = 8'hBB;
    dut.ram.memory[22] = 8'hCC; dut.ram.memory[23] = 8'hDD;
    @(negedge main_clk);
    bus.rw = RW_WRITE; bus.size = SZ_WORD; bus.signed_ld = 1'b0;
    bus.address = 9'd20; bus.data_in = 32'h11223344; bus.mfa = 1'b1;
    repeat (3) @(posedge main_clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (bus.moc !== 1'b0) begin n_bad++; $display("FAIL rst_xfer_moc: got %b want 0", bus.moc); end
    n_cmp++; if (bus.state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL rst_xfer_state: got %0d want %0d", bus.state_dbg, ST_IDLE); end
    @(negedge main_clk);
    bus.mfa = 1'b0;
    @(negedge main_clk);
    reset = 1'b1;
    n_cmp++; if ({dut.ram.memory[20], dut.ram.memory[21], dut.ram.memory[22], dut.ram.memory[23]} !== 32'h1122CCDD) begin
      n_bad++; $display("FAIL rst_xfer_mem: got %h want 1122CCDD", {dut.ram.memory[20], dut.ram.memory[21], dut.ram.memory[22], dut.ram.memory[23]}); end
    do_access(RW_READ, SZ_WORD, 1'b0, 9'd20, 32'h0, d, e, n);
    n_cmp++; if (d !== 32'h1122CCDD || e !== 1'b0 || n !== 5) begin n_bad++; $display("FAIL rst_xfer_next_read: got %h err=%b edges=%0d want 1122CCDD err=0 edges=5", d, e, n); end
  endtask

  task automatic test_mfa_drop();
    int first; int highs; logic [31:0] d;
    first = -1; highs = 0; d = '0;
    @(negedge main_clk);
    bus.rw = RW_READ; bus.size = SZ_WORD; bus.signed_ld = 1'b0; bus.address = 9'd0; bus.mfa = 1'b1;
    @(posedge main_clk);
    @(negedge main_clk);
    bus.mfa = 1'b0; bus.address = 9'd8; bus.rw = RW_WRITE;
    for (int i = 2; i <= 10; i++) begin
      @(posedge main_clk); #1;
      if (bus.moc) begin highs++; d = bus.data_out; if (first < 0) first = i; end
    end
    n_cmp++; if (first !== 5) begin n_bad++; $display("FAIL drop_latency: got %0d want 5", first); end
    n_cmp++; if (highs !== 1) begin n_bad++; $display("FAIL drop_moc_cycles: got %0d want 1", highs); end
    n_cmp++; if (d !== 32'hE3A01005) begin n_bad++; $display("FAIL drop_data: got %h want E3A01005", d); end
    n_cmp++; if (dut.ram.memory[8] !== 8'hDE) begin n_bad++; $display("FAIL drop_no_write: got %h want DE", dut.ram.memory[8]); end
  endtask

  task automatic test_mfa_held();
    logic [31:0] d; logic e; int n; int highs; int non_ack;
    highs = 0; non_ack = 0;
    @(negedge main_clk);
    bus.rw = RW_READ; bus.size = SZ_BYTE; bus.signed_ld = 1'b0; bus.address = 9'd3; bus.mfa = 1'b1;
    repeat (2) @(posedge main_clk);
    for (int i = 0; i < 6; i++) begin
      @(posedge main_clk); #1;
      if (bus.moc) highs++;
      if (bus.state_dbg !== ST_ACK) non_ack++;
    end
    n_cmp++; if (highs !== 6) begin n_bad++; $display("FAIL held_moc_cycles: got %0d want 6", highs); end
    n_cmp++; if (non_ack !== 0) begin n_bad++; $display("FAIL held_left_ack: got %0d want 0", non_ack); end
    n_cmp++; if (bus.data_out !== 32'h00000005) begin n_bad++; $display("FAIL held_data: got %h want 00000005", bus.data_out); end
    @(negedge main_clk);
    bus.mfa = 1'b0;
    @(posedge main_clk); #1;
    n_cmp++; if (bus.moc !== 1'b0 || bus.state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL held_release: got moc=%b state=%0d want moc=0 state=0", bus.moc, bus.state_dbg); end
    do_access(RW_READ, SZ_BYTE, 1'b0, 9'd0, 32'h0, d, e, n);
    n_cmp++; if (d !== 32'h000000E3 || n !== 2) begin n_bad++; $display("FAIL held_next_req: got %h edges=%0d want 000000E3 edges=2", d, n); end
  endtask

  initial begin
    bus.mfa = 1'b0; bus.rw = RW_READ; bus.size = SZ_BYTE; bus.signed_ld = 1'b0;
    bus.address = '0; bus.data_in = '0;
    test_reset();
    test_word_read();
    test_word_write();
    test_sign_ext();
    test_misaligned();
    test_reset_xfer();
    test_mfa_drop();
    test_mfa_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
